// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard/forwarding controller: stall FSM states,
// the register-file select constant and the nearest-stage forwarding search.
package hazard_pkg;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StLwait  = 2'd1,
    StMcwait = 2'd2
  } hz_state_e;

  localparam int unsigned FWD_SEL_RF = 0;

  // Upper bounds for the generic search; narrower configurations are zero-extended.
  localparam int unsigned FwdMaxStages = 8;
  localparam int unsigned FwdMaxAw     = 8;

  // Returns k+1 for the lowest stage k writing rs, or FWD_SEL_RF when none does or rs is x0.
  function automatic int unsigned fwd_sel(
    input logic [FwdMaxStages-1:0][FwdMaxAw-1:0] rd,
    input logic [FwdMaxStages-1:0]               we,
    input logic [FwdMaxAw-1:0]                   rs
  );
    int unsigned sel;
    sel = FWD_SEL_RF;
    if (rs != '0) begin
      // Walk from the farthest stage down so the nearest match is written last.
      for (int k = FwdMaxStages - 1; k >= 0; k--) begin
        if (we[k] && (rd[k] == rs)) sel = unsigned'(k + 1);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding select for one source register: picks the nearest forwarding
// stage that writes the register, else the register file.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic [REG_AW-1:0]            rs_i,
  input  logic [FWD_STAGES*REG_AW-1:0] rd_i,
  input  logic [FWD_STAGES-1:0]        we_i,
  output logic [SEL_W-1:0]             sel_o
);

  logic [FwdMaxStages-1:0][FwdMaxAw-1:0] rd_ext;
  logic [FwdMaxStages-1:0]               we_ext;

  always_comb begin
    rd_ext = '0;
    we_ext = '0;
    for (int k = 0; k < FWD_STAGES; k++) begin
      rd_ext[k] = FwdMaxAw'(rd_i[k*REG_AW +: REG_AW]);
      we_ext[k] = we_i[k];
    end
    sel_o = SEL_W'(fwd_sel(rd_ext, we_ext, FwdMaxAw'(rs_i)));
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller: operand forwarding, load-use and multi-cycle stall FSM
// with timeout. Defining HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned LOAD_LAT   = 0,
  parameter int unsigned MC_MAX     = 64,
  parameter int unsigned SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REG_AW-1:0]            i_EXEC_rs1,
  input  logic [REG_AW-1:0]            i_EXEC_rs2,
  input  logic [FWD_STAGES*REG_AW-1:0] i_FWD_rd,
  input  logic [FWD_STAGES-1:0]        i_FWD_reg_write,
  output logic [SEL_W-1:0]             o_FWD_rs1,
  output logic [SEL_W-1:0]             o_FWD_rs2,
  input  logic [REG_AW-1:0]            i_FETCH_rs1,
  input  logic [REG_AW-1:0]            i_FETCH_rs2,
  input  logic [REG_AW-1:0]            i_EXEC_rd,
  input  logic                         i_EXEC_mem2reg,
  input  logic                         i_EXEC_mc_start,
  input  logic                         i_MC_done,
  input  logic                         i_BRA,
  input  logic                         i_JMP,
  input  logic                         i_FETCH_valid,
  input  logic                         i_MEM_valid,
  output logic                         o_FETCH_stall,
  output logic                         o_EXEC_stall,
  output logic                         o_EXEC_flush,
  output logic                         o_MEM_flush,
`ifdef HAZARD_PERF_EN
  output logic [31:0]                  o_STALL_cnt,
  output logic [31:0]                  o_FLUSH_cnt,
`endif
  output logic                         o_MC_timeout
);

  localparam int unsigned CntW = $clog2(MC_MAX + 1);

  fwd_select #(
    .REG_AW    (REG_AW),
    .FWD_STAGES(FWD_STAGES),
    .SEL_W     (SEL_W)
  ) u_fwd_rs1 (
    .rs_i (i_EXEC_rs1),
    .rd_i (i_FWD_rd),
    .we_i (i_FWD_reg_write),
    .sel_o(o_FWD_rs1)
  );

  fwd_select #(
    .REG_AW    (REG_AW),
    .FWD_STAGES(FWD_STAGES),
    .SEL_W     (SEL_W)
  ) u_fwd_rs2 (
    .rs_i (i_EXEC_rs2),
    .rd_i (i_FWD_rd),
    .we_i (i_FWD_reg_write),
    .sel_o(o_FWD_rs2)
  );

  hz_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic            lu, dstall, redirect, exec_stall, fetch_stall;

  always_comb begin
    lu = i_EXEC_mem2reg & (i_EXEC_rd != '0) &
         ((i_EXEC_rd == i_FETCH_rs1) | (i_EXEC_rd == i_FETCH_rs2));
    dstall      = ~i_MEM_valid;
    redirect    = i_BRA | i_JMP;
    exec_stall  = dstall | ((state_q == StMcwait) & ~i_MC_done);
    fetch_stall = ~i_FETCH_valid | exec_stall | lu | (state_q == StLwait);

    // Reset forces stalls low and flushes high so the pipeline drains cleanly.
    o_EXEC_stall  = ~rst & exec_stall;
    o_FETCH_stall = ~rst & fetch_stall;
    o_MEM_flush   = rst | exec_stall;
    o_EXEC_flush  = rst | (~exec_stall & redirect) | fetch_stall;
    o_MC_timeout  = ~rst & timeout_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (i_MEM_valid) begin
      case (state_q)
        StRun: begin
          if (i_EXEC_mc_start) begin
            if (!i_MC_done) begin
              state_d = StMcwait;
              cnt_d   = '0;
            end
          end else if (lu && !redirect && (LOAD_LAT != 0)) begin
            // A redirect squashes the dependent instruction, so no load wait is needed.
            state_d = StLwait;
            cnt_d   = CntW'(LOAD_LAT);
          end
        end
        StLwait: begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_d = StRun;
        end
        StMcwait: begin
          if (i_MC_done) begin
            state_d = StRun;
          end else if (cnt_q == CntW'(MC_MAX - 1)) begin
            state_d   = StRun;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (o_FETCH_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (o_EXEC_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign o_STALL_cnt = stall_cnt_q;
  assign o_FLUSH_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the stall/flush rules.
module tb_hazard_scoreboard;

  localparam int unsigned AW    = 5;
  localparam int unsigned NST   = 3;
  localparam int unsigned LLAT  = 2;
  localparam int unsigned MCMAX = 8;
  localparam int unsigned SW    = $clog2(NST + 1);

  logic              clk;
  logic              rst;
  logic [AW-1:0]     exec_rs1, exec_rs2, fetch_rs1, fetch_rs2, exec_rd;
  logic [NST*AW-1:0] fwd_rd;
  logic [NST-1:0]    fwd_we;
  logic              mem2reg, mc_start, mc_done, bra, jmp, fetch_valid, mem_valid;
  logic [SW-1:0]     fwd_rs1, fwd_rs2;
  logic              fetch_stall, exec_stall, exec_flush, mem_flush, mc_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0]       stall_cnt, flush_cnt;
  int unsigned       m_stall_cnt = 0;
  int unsigned       m_flush_cnt = 0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state: remaining load-wait cycles, multi-cycle wait progress.
  int lwait_left = 0;
  bit mc_busy    = 1'b0;
  int mc_elapsed = 0;
  bit to_pulse   = 1'b0;

  hazard_scoreboard #(
    .REG_AW    (AW),
    .FWD_STAGES(NST),
    .LOAD_LAT  (LLAT),
    .MC_MAX    (MCMAX),
    .SEL_W     (SW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_EXEC_rs1     (exec_rs1),
    .i_EXEC_rs2     (exec_rs2),
    .i_FWD_rd       (fwd_rd),
    .i_FWD_reg_write(fwd_we),
    .o_FWD_rs1      (fwd_rs1),
    .o_FWD_rs2      (fwd_rs2),
    .i_FETCH_rs1    (fetch_rs1),
    .i_FETCH_rs2    (fetch_rs2),
    .i_EXEC_rd      (exec_rd),
    .i_EXEC_mem2reg (mem2reg),
    .i_EXEC_mc_start(mc_start),
    .i_MC_done      (mc_done),
    .i_BRA          (bra),
    .i_JMP          (jmp),
    .i_FETCH_valid  (fetch_valid),
    .i_MEM_valid    (mem_valid),
    .o_FETCH_stall  (fetch_stall),
    .o_EXEC_stall   (exec_stall),
    .o_EXEC_flush   (exec_flush),
    .o_MEM_flush    (mem_flush),
`ifdef HAZARD_PERF_EN
    .o_STALL_cnt    (stall_cnt),
    .o_FLUSH_cnt    (flush_cnt),
`endif
    .o_MC_timeout   (mc_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic int m_fwd(input logic [AW-1:0] rs);
    if (rs == '0) return 0;
    for (int k = 0; k < NST; k++) begin
      if (fwd_we[k] && (fwd_rd[k*AW +: AW] == rs)) return k + 1;
    end
    return 0;
  endfunction

  function automatic bit m_lu();
    return mem2reg && (exec_rd != '0) && ((exec_rd == fetch_rs1) || (exec_rd == fetch_rs2));
  endfunction

  function automatic bit m_exec_stall_raw();
    return !mem_valid || (mc_busy && !mc_done);
  endfunction

  function automatic bit m_exec_stall();
    return !rst && m_exec_stall_raw();
  endfunction

  function automatic bit m_fetch_stall();
    if (rst) return 1'b0;
    return !fetch_valid || m_exec_stall_raw() || m_lu() || (lwait_left > 0);
  endfunction

  function automatic bit m_exec_flush();
    if (rst) return 1'b1;
    return (!m_exec_stall_raw() && (bra || jmp)) || m_fetch_stall();
  endfunction

  function automatic bit m_mem_flush();
    return rst || m_exec_stall_raw();
  endfunction

  function automatic bit m_timeout();
    return !rst && to_pulse;
  endfunction

  // Advance the model across one rising edge using the inputs held during the cycle.
  function automatic void model_clock();
    bit to_next;
    to_next = 1'b0;
`ifdef HAZARD_PERF_EN
    if (rst) begin
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      if (m_fetch_stall() && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
      if (m_exec_flush() && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
    end
`endif
    if (rst) begin
      lwait_left = 0;
      mc_busy    = 1'b0;
      mc_elapsed = 0;
    end else if (mem_valid) begin
      if (lwait_left > 0) begin
        lwait_left--;
      end else if (mc_busy) begin
        if (mc_done) mc_busy = 1'b0;
        else if (mc_elapsed + 1 == MCMAX) begin
          mc_busy = 1'b0;
          to_next = 1'b1;
        end else mc_elapsed++;
      end else if (mc_start) begin
        if (!mc_done) begin
          mc_busy    = 1'b1;
          mc_elapsed = 0;
        end
      end else if (m_lu() && !(bra || jmp)) begin
        lwait_left = LLAT;
      end
    end
    to_pulse = to_next;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; exec_rs1 = '0; exec_rs2 = '0; fetch_rs1 = '0; fetch_rs2 = '0; exec_rd = '0;
    fwd_rd = '0; fwd_we = '0; mem2reg = 1'b0; mc_start = 1'b0; mc_done = 1'b0;
    bra = 1'b0; jmp = 1'b0; fetch_valid = 1'b1; mem_valid = 1'b1;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    idle();
    rst = 1'b1; mem_valid = 1'b0; fetch_valid = 1'b0; jmp = 1'b1; mc_start = 1'b1;
    tick(); tick();
    #2;
    n_checks += 4;
    if (fetch_stall !== 1'b0) begin n_errors++; $display("FAIL reset_fetch_stall got=%b exp=0", fetch_stall); end
    if (exec_stall !== 1'b0) begin n_errors++; $display("FAIL reset_exec_stall got=%b exp=0", exec_stall); end
    if (exec_flush !== 1'b1 || mem_flush !== 1'b1) begin
      n_errors++; $display("FAIL reset_flushes got=%b%b exp=11", exec_flush, mem_flush);
    end
    if (mc_timeout !== 1'b0) begin n_errors++; $display("FAIL reset_timeout got=%b exp=0", mc_timeout); end
    tick();
    idle();
    #2;
    n_checks++;
    if ({fetch_stall, exec_stall, exec_flush, mem_flush} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_release got=%b exp=0000", {fetch_stall, exec_stall, exec_flush, mem_flush});
    end
    tick();
  endtask

  task automatic test_forward();
    idle();
    fwd_rd = {5'd9, 5'd5, 5'd5}; fwd_we = 3'b011; exec_rs1 = 5'd5; exec_rs2 = 5'd9;
    #2;
    n_checks += 2;
    if (fwd_rs1 !== 2'd1) begin n_errors++; $display("FAIL fwd_nearest got=%0d exp=1", fwd_rs1); end
    if (fwd_rs2 !== 2'd0) begin n_errors++; $display("FAIL fwd_stage2_off got=%0d exp=0", fwd_rs2); end
    tick();
    fwd_we = 3'b110;
    #2;
    n_checks += 2;
    if (fwd_rs1 !== 2'd2) begin n_errors++; $display("FAIL fwd_wb got=%0d exp=2", fwd_rs1); end
    if (fwd_rs2 !== 2'd3) begin n_errors++; $display("FAIL fwd_stage2 got=%0d exp=3", fwd_rs2); end
    tick();
    exec_rs1 = '0; fwd_rd = '0; fwd_we = 3'b111;
    #2;
    n_checks++;
    if (fwd_rs1 !== 2'd0) begin n_errors++; $display("FAIL fwd_x0 got=%0d exp=0", fwd_rs1); end
    tick();
    for (int i = 0; i < 20; i++) begin
      fwd_rd = NST*AW'($urandom_range(0, 32767)) & {NST{5'b00011}};
      fwd_we = NST'($urandom);
      exec_rs1 = AW'($urandom_range(0, 3)); exec_rs2 = AW'($urandom_range(0, 3));
      #2;
      n_checks++;
      if (fwd_rs1 !== SW'(m_fwd(exec_rs1)) || fwd_rs2 !== SW'(m_fwd(exec_rs2))) begin
        n_errors++;
        $display("FAIL fwd_rand i=%0d got=%0d,%0d exp=%0d,%0d", i, fwd_rs1, fwd_rs2,
                 m_fwd(exec_rs1), m_fwd(exec_rs2));
      end
      tick();
    end
    idle();
  endtask

  task automatic test_load_use();
    bit exp;
    idle();
    for (int c = 0; c < 4; c++) begin
      mem2reg = (c == 0); exec_rd = (c == 0) ? 5'd7 : 5'd0;
      fetch_rs1 = 5'd3; fetch_rs2 = 5'd7;
      #2;
      exp = (c < 3);
      n_checks++;
      if (fetch_stall !== exp || exec_flush !== exp) begin
        n_errors++;
        $display("FAIL load_use c=%0d got=%b/%b exp=%b", c, fetch_stall, exec_flush, exp);
      end
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      mem2reg = (c == 0); exec_rd = '0; fetch_rs1 = '0; fetch_rs2 = 5'd7;
      #2;
      n_checks++;
      if (fetch_stall !== 1'b0) begin
        n_errors++; $display("FAIL load_x0 c=%0d got=%b exp=0", c, fetch_stall);
      end
      tick();
    end
    // Redirect in the load-use cycle: stall now, but no load wait afterwards.
    mem2reg = 1'b1; exec_rd = 5'd4; fetch_rs1 = 5'd4; bra = 1'b1;
    #2;
    n_checks++;
    if (fetch_stall !== 1'b1) begin n_errors++; $display("FAIL lu_bra_now got=%b exp=1", fetch_stall); end
    tick();
    idle();
    #2;
    n_checks++;
    if (fetch_stall !== 1'b0) begin n_errors++; $display("FAIL lu_bra_after got=%b exp=0", fetch_stall); end
    tick();
  endtask

  task automatic test_multicycle();
    bit exp;
    idle();
    for (int c = 0; c <= 6; c++) begin
      mc_start = (c == 0); mc_done = (c == 5);
      #2;
      exp = (c >= 1 && c <= 4);
      n_checks++;
      if (exec_stall !== exp || mem_flush !== exp || fetch_stall !== exp) begin
        n_errors++;
        $display("FAIL mc_done c=%0d got=%b%b%b exp=%b", c, exec_stall, mem_flush, fetch_stall, exp);
      end
      tick();
    end
    idle();
    for (int c = 0; c <= 10; c++) begin
      mc_start = (c == 0);
      #2;
      n_checks += 2;
      if (exec_stall !== (c >= 1 && c <= 8)) begin
        n_errors++; $display("FAIL mc_to_stall c=%0d got=%b", c, exec_stall);
      end
      if (mc_timeout !== (c == 9)) begin
        n_errors++; $display("FAIL mc_timeout c=%0d got=%b exp=%b", c, mc_timeout, c == 9);
      end
      tick();
    end
  endtask

  task automatic test_branch_vs_stall();
    idle();
    jmp = 1'b1; mem_valid = 1'b0;
    #2;
    n_checks += 2;
    if (exec_flush !== fetch_stall || exec_flush !== 1'b1) begin
      n_errors++; $display("FAIL jmp_dstall got=%b/%b exp=1/1", exec_flush, fetch_stall);
    end
    if (exec_stall !== 1'b1) begin n_errors++; $display("FAIL jmp_dstall_exec got=%b exp=1", exec_stall); end
    tick();
    mem_valid = 1'b1;
    #2;
    n_checks++;
    if ({exec_flush, fetch_stall, exec_stall, mem_flush} !== 4'b1000) begin
      n_errors++;
      $display("FAIL jmp_release got=%b exp=1000", {exec_flush, fetch_stall, exec_stall, mem_flush});
    end
    tick();
    idle();
  endtask

  task automatic test_reset_mid_mcwait();
    idle();
    for (int c = 0; c < 4; c++) begin
      mc_start = (c == 0);
      tick();
    end
    rst = 1'b1;
    #2;
    n_checks++;
    if ({fetch_stall, exec_stall, exec_flush, mem_flush, mc_timeout} !== 5'b00110) begin
      n_errors++;
      $display("FAIL rst_mc_during got=%b exp=00110",
               {fetch_stall, exec_stall, exec_flush, mem_flush, mc_timeout});
    end
    tick();
    idle();
    #2;
    n_checks++;
    if ({fetch_stall, exec_stall, exec_flush, mem_flush} !== 4'b0000) begin
      n_errors++;
      $display("FAIL rst_mc_after got=%b exp=0000", {fetch_stall, exec_stall, exec_flush, mem_flush});
    end
`ifdef HAZARD_PERF_EN
    n_checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      n_errors++; $display("FAIL rst_perf got=%0d,%0d exp=0,0", stall_cnt, flush_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) < 2);
      exec_rs1 = AW'($urandom_range(0, 3)); exec_rs2 = AW'($urandom_range(0, 3));
      fetch_rs1 = AW'($urandom_range(0, 3)); fetch_rs2 = AW'($urandom_range(0, 3));
      exec_rd = AW'($urandom_range(0, 3));
      fwd_rd = NST*AW'($urandom_range(0, 32767)) & {NST{5'b00011}};
      fwd_we = NST'($urandom);
      mem2reg = ($urandom_range(0, 99) < 30);
      mc_start = ($urandom_range(0, 99) < 10);
      mc_done = ($urandom_range(0, 99) < 15);
      bra = ($urandom_range(0, 99) < 8);
      jmp = ($urandom_range(0, 99) < 5);
      fetch_valid = ($urandom_range(0, 99) < 90);
      mem_valid = ($urandom_range(0, 99) < 85);
      #2;
      n_checks++;
      if (fwd_rs1 !== SW'(m_fwd(exec_rs1)) || fwd_rs2 !== SW'(m_fwd(exec_rs2))) begin
        n_errors++;
        $display("FAIL rnd_fwd c=%0d got=%0d,%0d exp=%0d,%0d", c, fwd_rs1, fwd_rs2,
                 m_fwd(exec_rs1), m_fwd(exec_rs2));
      end
      n_checks++;
      if ({fetch_stall, exec_stall, exec_flush, mem_flush, mc_timeout} !==
          {m_fetch_stall(), m_exec_stall(), m_exec_flush(), m_mem_flush(), m_timeout()}) begin
        n_errors++;
        $display("FAIL rnd_ctrl c=%0d got=%b exp=%b", c,
                 {fetch_stall, exec_stall, exec_flush, mem_flush, mc_timeout},
                 {m_fetch_stall(), m_exec_stall(), m_exec_flush(), m_mem_flush(), m_timeout()});
      end
`ifdef HAZARD_PERF_EN
      n_checks++;
      if (stall_cnt !== m_stall_cnt || flush_cnt !== m_flush_cnt) begin
        n_errors++;
        $display("FAIL rnd_perf c=%0d got=%0d,%0d exp=%0d,%0d", c, stall_cnt, flush_cnt,
                 m_stall_cnt, m_flush_cnt);
      end
`endif
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_forward();
    test_load_use();
    test_multicycle();
    test_branch_vs_stall();
    test_reset_mid_mcwait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
